// File: rtl/score_pkg.sv
// Shared types for the score counter: debounce states and BCD digit helpers.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } deb_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // One BCD digit plus the carry it produces into the next digit.
    typedef struct packed {
        logic       carry;
        bcd_digit_t digit;
    } bcd_step_t;

    // Add a carry-in to one BCD digit; 9 + 1 gives 0 with carry-out.
    function automatic bcd_step_t bcd_inc(input bcd_digit_t d, input logic cin);
        bcd_step_t r;
        r.carry = 1'b0;
        r.digit = d;
        if (cin) begin
            if (d >= BCD_MAX) begin
                r.digit = '0;
                r.carry = 1'b1;
            end else begin
                r.digit = d + 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_fsm.sv
// Button synchroniser plus debounce FSM; emits a one-cycle accept strobe
// on the edge where a press has been stable for DEB_CYCLES clocks.
module debounce_fsm
    import score_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic PBTON,
    output logic o_press
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    r_sync;
    deb_state_t    r_state;
    logic [CW-1:0] r_cnt;

    logic          w_btn_s;
    deb_state_t    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;

    assign w_btn_s = r_sync[1];

    // State, counter and synchroniser registers; reset parks the FSM in HELD
    // so a button held through reset is never counted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync  <= '0;
            r_state <= HELD;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], PBTON};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and accept strobe; the strobe depends only on registers,
    // so the top can capture it on the same edge the FSM enters HELD.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_press     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_btn_s) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HELD;
                    o_press     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_btn_s) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_btn_s) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = HELD;
        endcase
    end

endmodule

// File: rtl/score_bcd_counter.sv
// Debounced push-button feeding a 3-digit BCD score (000..999) for the
// seven-segment painters; optional wrap with ROLL pulse, otherwise saturate.
module score_bcd_counter
    import score_pkg::*;
#(
    parameter int unsigned FPGAFREQ    = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned DEB_CYCLES  = FPGAFREQ / 1000 * DEBOUNCE_MS,
    parameter bit          WRAP        = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PBTON,
    input  logic       CLR,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       PRESS,
    output logic       ROLL
);

    logic      w_accept;
    bcd_step_t w_u;
    bcd_step_t w_t;
    bcd_step_t w_h;
    logic      w_top_carry;

    debounce_fsm #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .CLK    (CLK),
        .RST    (RST),
        .PBTON  (PBTON),
        .o_press(w_accept)
    );

    // Ripple carry through the three digits; a carry out of hundreds means 999.
    always_comb begin
        w_u         = bcd_inc(units, 1'b1);
        w_t         = bcd_inc(tens, w_u.carry);
        w_h         = bcd_inc(hundreds, w_t.carry);
        w_top_carry = w_h.carry;
    end

    // Registered score and pulses; CLR beats an accepted press on the same edge
    // but PRESS still reports the press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            units    <= '0;
            tens     <= '0;
            hundreds <= '0;
            PRESS    <= 1'b0;
            ROLL     <= 1'b0;
        end else begin
            PRESS <= w_accept;
            ROLL  <= 1'b0;
            if (CLR) begin
                units    <= '0;
                tens     <= '0;
                hundreds <= '0;
            end else if (w_accept) begin
                if (!w_top_carry || WRAP) begin
                    units    <= w_u.digit;
                    tens     <= w_t.digit;
                    hundreds <= w_h.digit;
                    ROLL     <= w_top_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_bcd_counter.sv
// Directed bench for score_bcd_counter with DEB_CYCLES=4; a wrapping and a
// saturating instance share the same stimulus.
module tb_score_bcd_counter;

    logic       clk;
    logic       rst;
    logic       pbton;
    logic       clr;

    logic [3:0] units_w, tens_w, hundreds_w;
    logic       press_w, roll_w;
    logic [3:0] units_s, tens_s, hundreds_s;
    logic       press_s, roll_s;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned press_cnt;
    int unsigned roll_cnt_w;
    int unsigned roll_cnt_s;
    int unsigned p0;

    score_bcd_counter #(
        .DEB_CYCLES(4),
        .WRAP      (1'b1)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .PBTON   (pbton),
        .CLR     (clr),
        .units   (units_w),
        .tens    (tens_w),
        .hundreds(hundreds_w),
        .PRESS   (press_w),
        .ROLL    (roll_w)
    );

    score_bcd_counter #(
        .DEB_CYCLES(4),
        .WRAP      (1'b0)
    ) dut_sat (
        .CLK     (clk),
        .RST     (rst),
        .PBTON   (pbton),
        .CLR     (clr),
        .units   (units_s),
        .tens    (tens_s),
        .hundreds(hundreds_s),
        .PRESS   (press_s),
        .ROLL    (roll_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (press_w) press_cnt++;
        if (roll_w)  roll_cnt_w++;
        if (roll_s)  roll_cnt_s++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then let the FSM walk HELD -> RELEASE_WAIT -> IDLE with the button low.
    task automatic apply_reset();
        rst   = 1'b1;
        pbton = 1'b0;
        clr   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
    endtask

    task automatic press(input int unsigned hold);
        pbton = 1'b1;
        repeat (hold) tick();
        pbton = 1'b0;
        repeat (9) tick();
    endtask

    function automatic int unsigned dig_w();
        return {20'd0, hundreds_w, tens_w, units_w};
    endfunction

    function automatic int unsigned dig_s();
        return {20'd0, hundreds_s, tens_s, units_s};
    endfunction

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        press_cnt  = 0;
        roll_cnt_w = 0;
        roll_cnt_s = 0;
        rst        = 1'b1;
        pbton      = 1'b0;
        clr        = 1'b0;

        // 1: reset state, latency of a clean press, single pulse while held
        tick();
        chk("rst_digits", dig_w(), 32'h000);
        chk("rst_press", press_w, 0);
        chk("rst_roll", roll_w, 0);
        apply_reset();
        p0    = press_cnt;
        pbton = 1'b1;
        repeat (6) tick();
        chk("t1_press_edge6", press_w, 0);
        chk("t1_digits_edge6", dig_w(), 32'h000);
        tick();
        chk("t1_press_edge7", press_w, 1);
        chk("t1_digits_edge7", dig_w(), 32'h001);
        chk("t1_roll_edge7", roll_w, 0);
        tick();
        chk("t1_press_edge8", press_w, 0);
        repeat (12) tick();
        chk("t1_one_press_held", press_cnt - p0, 1);
        chk("t1_digits_held", dig_w(), 32'h001);
        pbton = 1'b0;
        repeat (9) tick();

        // 2: short bounces rejected on press and on release
        apply_reset();
        p0 = press_cnt;
        for (int i = 0; i < 4; i++) begin
            pbton = (i % 2 == 0);
            tick();
        end
        pbton = 1'b1;
        repeat (12) tick();
        for (int i = 0; i < 5; i++) begin
            pbton = (i % 2 == 1);
            tick();
        end
        pbton = 1'b0;
        repeat (10) tick();
        chk("t2_one_press", press_cnt - p0, 1);
        chk("t2_digits", dig_w(), 32'h001);

        // 3: carries, wrap and saturate at 999
        apply_reset();
        for (int i = 0; i < 99; i++) press(8);
        chk("t3_digits_099", dig_w(), 32'h099);
        press(8);
        chk("t3_digits_100", dig_w(), 32'h100);
        for (int i = 0; i < 899; i++) press(8);
        chk("t3_digits_999_wrap", dig_w(), 32'h999);
        chk("t3_digits_999_sat", dig_s(), 32'h999);
        chk("t3_no_roll_yet", roll_cnt_w, 0);
        pbton = 1'b1;
        repeat (7) tick();
        chk("t3_wrap_press", press_w, 1);
        chk("t3_wrap_roll", roll_w, 1);
        chk("t3_wrap_digits", dig_w(), 32'h000);
        chk("t3_sat_press", press_s, 1);
        chk("t3_sat_roll", roll_s, 0);
        chk("t3_sat_digits", dig_s(), 32'h999);
        tick();
        chk("t3_roll_one_cycle", roll_w, 0);
        pbton = 1'b0;
        repeat (9) tick();
        chk("t3_roll_count_wrap", roll_cnt_w, 1);
        chk("t3_roll_count_sat", roll_cnt_s, 0);

        // 4: CLR colliding with an accepted press, then CLR alone
        apply_reset();
        for (int i = 0; i < 42; i++) press(8);
        chk("t4_digits_042", dig_w(), 32'h042);
        pbton = 1'b1;
        repeat (6) tick();
        clr = 1'b1;
        tick();
        chk("t4_clr_press_press", press_w, 1);
        chk("t4_clr_press_digits", dig_w(), 32'h000);
        chk("t4_clr_press_roll", roll_w, 0);
        clr   = 1'b0;
        pbton = 1'b0;
        repeat (9) tick();
        for (int i = 0; i < 5; i++) press(8);
        chk("t4_digits_005", dig_w(), 32'h005);
        clr = 1'b1;
        tick();
        chk("t4_clr_alone", dig_w(), 32'h000);
        clr = 1'b0;
        press(8);
        chk("t4_fsm_intact", dig_w(), 32'h001);

        // 5: button held through reset release is ignored
        rst   = 1'b1;
        pbton = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        p0  = press_cnt;
        repeat (20) tick();
        chk("t5_no_press_held", press_cnt - p0, 0);
        chk("t5_digits_held", dig_w(), 32'h000);
        pbton = 1'b0;
        repeat (9) tick();
        press(8);
        chk("t5_repress_count", press_cnt - p0, 1);
        chk("t5_repress_digits", dig_w(), 32'h001);

        // 6: reset in the middle of a press debounce
        apply_reset();
        press(8);
        chk("t6_digits_pre", dig_w(), 32'h001);
        p0    = press_cnt;
        pbton = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_digits", dig_w(), 32'h000);
        chk("t6_rst_press", press_w, 0);
        chk("t6_rst_roll", roll_w, 0);
        rst = 1'b0;
        repeat (10) tick();
        chk("t6_no_press", press_cnt - p0, 0);
        pbton = 1'b0;
        repeat (9) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
